// File: rtl/seq_mult_nb_pkg.sv
// Shared constants for the sequential divider/multiplier family: FSM encodings
// and the iteration-counter width helper.
package seq_mult_nb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  // Counter spans 0..n-1; a 1-bit floor keeps small n legal.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_mult_dp.sv
// Shift-add datapath: multiplicand register, (2n+1)-bit accumulator, ripple adder.
// load_i captures operands; step_i performs one conditional add plus right shift.
module seq_mult_dp #(
  parameter int n = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [n-1:0]     a_i,
  input  logic [n-1:0]     b_i,
  output logic [2*n-1:0]   prod_nxt_o
);

  logic [n-1:0]   m_q, m_d;
  logic [2*n:0]   acc_q, acc_d;
  logic [n-1:0]   addend;
  logic [n:0]     sum;
  logic           c;
  logic [2*n:0]   acc_shift;

  // Ripple-carry add of M (or 0) into {carry, hi}; the top stage only absorbs carry.
  always_comb begin
    c      = 1'b0;
    sum    = '0;
    addend = acc_q[0] ? m_q : '0;
    for (int i = 0; i < n; i++) begin
      sum[i] = acc_q[n+i] ^ addend[i] ^ c;
      c      = (acc_q[n+i] & addend[i]) | (c & (acc_q[n+i] ^ addend[i]));
    end
    sum[n] = acc_q[2*n] ^ c;
  end

  assign acc_shift  = {1'b0, sum, acc_q[n-1:1]};
  assign prod_nxt_o = acc_shift[2*n-1:0];

  always_comb begin
    m_d   = m_q;
    acc_d = acc_q;
    if (load_i) begin
      m_d   = a_i;
      acc_d = {1'b0, {n{1'b0}}, b_i};
    end else if (step_i) begin
      acc_d = acc_shift;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      m_q   <= '0;
      acc_q <= '0;
    end else begin
      m_q   <= m_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/seq_mult_nb.sv
// Radix-2 sequential unsigned multiplier: n CALC cycles per product, one-cycle done.
// start is honoured only in IDLE or DONE, so DONE-to-CALC runs back-to-back.
module seq_mult_nb
  import seq_mult_nb_pkg::*;
#(
  parameter int n = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [n-1:0]     a,
  input  logic [n-1:0]     b,
  output logic [2*n-1:0]   prod,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_width(n);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*n-1:0]    prod_q, prod_d;
  logic [2*n-1:0]    prod_nxt;
  logic              load, step;

  seq_mult_dp #(.n(n)) u_dp (
    .clk        (clk),
    .clr        (clr),
    .load_i     (load),
    .step_i     (step),
    .a_i        (a),
    .b_i        (b),
    .prod_nxt_o (prod_nxt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          load    = 1'b1;
          cnt_d   = '0;
        end
      end
      CALC: begin
        step  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        // Last iteration: capture the post-step accumulator as the product.
        if (cnt_q == CW'(n - 1)) begin
          state_d = DONE;
          prod_d  = prod_nxt;
        end
      end
      DONE: begin
        if (start) begin
          state_d = CALC;
          load    = 1'b1;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign prod = prod_q;
  assign busy = (state_q == CALC);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_seq_mult_nb.sv
// Scoreboard bench for seq_mult_nb (n=8): stimulus pushes expected products,
// a negedge monitor pops them on done and checks prod holds in between.
module tb_seq_mult_nb;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           clr;
  logic           start;
  logic [N-1:0]   a, b;
  logic [2*N-1:0] prod;
  logic           busy, done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [2*N-1:0] exp_q[$];
  logic [2*N-1:0] held = '0;

  seq_mult_nb #(.n(N)) dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .a     (a),
    .b     (b),
    .prod  (prod),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y);
    int unsigned p;
    p = int'(x) * int'(y);
    return p[2*N-1:0];
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic drive(input logic s, input logic [N-1:0] x, input logic [N-1:0] y);
    @(posedge clk);
    #1;
    start = s;
    a     = x;
    b     = y;
  endtask

  // Counts negedges until done is seen (bounded); busy cycles counted along the way.
  task automatic wait_done(output int cyc, output int bcyc);
    bit seen;
    cyc  = 0;
    bcyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 2*N + 8) begin
      @(negedge clk);
      cyc++;
      if (busy === 1'b1) bcyc++;
      if (done === 1'b1) seen = 1'b1;
    end
    check("done_seen", {63'd0, seen}, 64'd1);
  endtask

  task automatic run_one(input logic [N-1:0] x, input logic [N-1:0] y);
    int cyc, bcyc;
    drive(1'b1, x, y);
    exp_q.push_back(ref_mul(x, y));
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc, bcyc);
    check("latency", cyc, N + 1);
    check("busy_cycles", bcyc, N);
    @(negedge clk);
    check("done_single", {63'd0, done}, 64'd0);
  endtask

  // Monitor: every done pops one expectation; otherwise prod must hold.
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        check("done_has_request", {63'd0, exp_q.size() != 0}, 64'd1);
        if (exp_q.size() != 0) begin
          held = exp_q.pop_front();
          check("prod_at_done", prod, held);
        end
      end else begin
        check("prod_hold", prod, held);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1);
  end

  initial begin
    int cyc, bcyc;
    logic [N-1:0] x, y;
    clr   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("reset_prod", prod, 0);
    check("reset_busy", {63'd0, busy}, 0);
    check("reset_done", {63'd0, done}, 0);
    @(posedge clk);
    #1;
    clr = 1'b0;

    run_one(8'd13, 8'd11);
    check("prod_13x11", prod, 143);
    run_one(8'd255, 8'd255);
    check("prod_255x255", prod, 65025);
    run_one(8'd0, 8'd200);
    check("prod_0x200", prod, 0);
    run_one(8'd200, 8'd0);
    check("prod_200x0", prod, 0);

    // Start during CALC cycle 4 must be ignored.
    drive(1'b1, 8'd3, 8'd5);
    exp_q.push_back(ref_mul(8'd3, 8'd5));
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    a     = 8'd9;
    b     = 8'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc, bcyc);
    check("prod_ignored_start", prod, 15);
    repeat (12) @(negedge clk);
    check("prod_after_ignore", prod, 15);
    check("idle_after_ignore", {63'd0, busy}, 0);

    // Back-to-back: start held through DONE with new operands.
    drive(1'b1, 8'd7, 8'd6);
    exp_q.push_back(ref_mul(8'd7, 8'd6));
    @(posedge clk);
    #1;
    a = 8'd10;
    b = 8'd10;
    exp_q.push_back(ref_mul(8'd10, 8'd10));
    wait_done(cyc, bcyc);
    check("b2b_first_latency", cyc, N + 1);
    check("b2b_first_prod", prod, 42);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc, bcyc);
    check("b2b_gap", cyc, N + 1);
    check("b2b_busy", bcyc, N);
    check("b2b_second_prod", prod, 100);
    @(negedge clk);
    check("b2b_done_drop", {63'd0, done}, 0);

    // clr in CALC cycle 5 aborts; start while clr is high is ignored.
    drive(1'b1, 8'd100, 8'd100);
    exp_q.push_back(ref_mul(8'd100, 8'd100));
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    clr = 1'b1;
    exp_q.delete();
    held = '0;
    #1;
    check("clr_prod", prod, 0);
    check("clr_busy", {63'd0, busy}, 0);
    check("clr_done", {63'd0, done}, 0);
    start = 1'b1;
    a     = 8'd50;
    b     = 8'd50;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    clr   = 1'b0;
    repeat (N + 4) @(negedge clk);
    check("no_done_after_clr", {63'd0, done}, 0);
    check("no_busy_after_clr", {63'd0, busy}, 0);
    run_one(8'd2, 8'd3);
    check("prod_2x3", prod, 6);

    for (int k = 0; k < 24; k++) begin
      x = N'($urandom_range(0, 255));
      y = N'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_one(x, y);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
